// File: rtl/lpc_io_cycle_ctrl.sv
// LPC slave I/O read/write sequencer for a 32-register window at BASE_ADDR.
// Optional SYNC short-wait insertion: define LPC_WAIT_SYNC_EN.
module lpc_io_cycle_ctrl #(
  parameter logic [15:0] BASE_ADDR  = 16'h0700,
  parameter int unsigned SYNC_WAITS = 2
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFRAME_n,
  input  logic [3:0] LAD_in,
  output logic [3:0] LAD_out,
  output logic       LAD_oe,
  output logic [7:0] AddrReg,
  input  logic [7:0] DataRd,
  output logic [7:0] WrData,
  output logic       WrStrobe,
  output logic       RdStrobe
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_WDATA0 = 4'd3;
  localparam logic [3:0] S_WDATA1 = 4'd4;
  localparam logic [3:0] S_HTAR0  = 4'd5;
  localparam logic [3:0] S_HTAR1  = 4'd6;
  localparam logic [3:0] S_SYNC   = 4'd7;
  localparam logic [3:0] S_RDATA0 = 4'd8;
  localparam logic [3:0] S_RDATA1 = 4'd9;
  localparam logic [3:0] S_PTAR0  = 4'd10;
  localparam logic [3:0] S_PTAR1  = 4'd11;

  logic [3:0]  state_q, state_d;
  logic [1:0]  nib_q, nib_d;
  logic [11:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_reg_q, addr_reg_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] addr_full;
  logic        sync_last;

`ifdef LPC_WAIT_SYNC_EN
  localparam logic [3:0] WAIT_INIT = 4'(SYNC_WAITS);
  logic [3:0] wait_q, wait_d;
  assign sync_last = (wait_q == 4'd0);
`else
  assign sync_last = 1'b1;
`endif

  assign addr_full = {addr_q, LAD_in};

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    addr_reg_d = addr_reg_q;
    wr_data_d  = wr_data_q;
    hold_d     = hold_q;
`ifdef LPC_WAIT_SYNC_EN
    wait_d     = wait_q;
`endif
    // A frame start or abort overrides whatever cycle is in flight.
    if (!LFRAME_n) begin
      state_d = (LAD_in == 4'h0) ? S_START : S_IDLE;
    end else begin
      case (state_q)
        S_START: begin
          nib_d = 2'd0;
          if (LAD_in == 4'h0) begin
            wr_d = 1'b0; state_d = S_ADDR;
          end else if (LAD_in == 4'h2) begin
            wr_d = 1'b1; state_d = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          addr_d = {addr_q[7:0], LAD_in};
          nib_d  = nib_q + 2'd1;
          if (nib_q == 2'd3) begin
            if (addr_full[15:5] == BASE_ADDR[15:5]) begin
              addr_reg_d = {3'b000, addr_full[4:0]};
              state_d    = wr_q ? S_WDATA0 : S_HTAR0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_WDATA0: begin
          wr_data_d[3:0] = LAD_in;
          state_d        = S_WDATA1;
        end
        S_WDATA1: begin
          wr_data_d[7:4] = LAD_in;
          state_d        = S_HTAR0;
        end
        S_HTAR0: state_d = S_HTAR1;
        S_HTAR1: begin
          state_d = S_SYNC;
`ifdef LPC_WAIT_SYNC_EN
          wait_d = WAIT_INIT;
          if (!wr_q && WAIT_INIT == 4'd0) hold_d = DataRd;
`else
          if (!wr_q) hold_d = DataRd;
`endif
        end
        S_SYNC: begin
          if (sync_last) begin
            state_d = wr_q ? S_PTAR0 : S_RDATA0;
          end else begin
`ifdef LPC_WAIT_SYNC_EN
            // Hold register loads on entry to the final ready SYNC.
            wait_d = wait_q - 4'd1;
            if (!wr_q && wait_q == 4'd1) hold_d = DataRd;
`endif
          end
        end
        S_RDATA0: state_d = S_RDATA1;
        S_RDATA1: state_d = S_PTAR0;
        S_PTAR0:  state_d = S_PTAR1;
        S_PTAR1:  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q    <= S_IDLE;
      nib_q      <= 2'd0;
      addr_q     <= 12'd0;
      wr_q       <= 1'b0;
      addr_reg_q <= 8'd0;
      wr_data_q  <= 8'd0;
      hold_q     <= 8'd0;
`ifdef LPC_WAIT_SYNC_EN
      wait_q     <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      addr_reg_q <= addr_reg_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
`ifdef LPC_WAIT_SYNC_EN
      wait_q     <= wait_d;
`endif
    end
  end

  // LAD drive decodes from the state flop, so reset releases the bus immediately.
  always_comb begin
    LAD_oe  = 1'b0;
    LAD_out = 4'hF;
    case (state_q)
      S_SYNC: begin
        LAD_oe  = 1'b1;
        LAD_out = sync_last ? 4'h0 : 4'h5;
      end
      S_RDATA0: begin LAD_oe = 1'b1; LAD_out = hold_q[3:0]; end
      S_RDATA1: begin LAD_oe = 1'b1; LAD_out = hold_q[7:4]; end
      S_PTAR0:  LAD_oe = 1'b1;
      default:  ;
    endcase
  end

  assign AddrReg  = addr_reg_q;
  assign WrData   = wr_data_q;
  assign WrStrobe = (state_q == S_SYNC) && wr_q && sync_last;
  assign RdStrobe = (state_q == S_HTAR0) && !wr_q;

endmodule

// File: tb/tb_lpc_io_cycle_ctrl.sv
// Directed bench for lpc_io_cycle_ctrl: reads, writes, window miss, abort, async reset.
module tb_lpc_io_cycle_ctrl;
`ifdef LPC_WAIT_SYNC_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b0;
  logic       LFRAME_n = 1'b1;
  logic [3:0] LAD_in   = 4'hF;
  logic [3:0] LAD_out;
  logic       LAD_oe;
  logic [7:0] AddrReg;
  logic [7:0] DataRd   = 8'h00;
  logic [7:0] WrData;
  logic       WrStrobe;
  logic       RdStrobe;

  int n_chk  = 0;
  int n_pass = 0;

  lpc_io_cycle_ctrl dut (
    .LpcClock(LpcClock), .PciReset(PciReset), .LFRAME_n(LFRAME_n),
    .LAD_in(LAD_in), .LAD_out(LAD_out), .LAD_oe(LAD_oe),
    .AddrReg(AddrReg), .DataRd(DataRd), .WrData(WrData),
    .WrStrobe(WrStrobe), .RdStrobe(RdStrobe)
  );

  always #15 LpcClock = ~LpcClock;

  // Registered read mux model: index ^ 0xA4 (0x01 -> A5, 0x1F -> BB, 0x05 -> A1).
  always @(posedge LpcClock) DataRd <= AddrReg ^ 8'hA4;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic fr, input logic [3:0] lad);
    LFRAME_n = fr;
    LAD_in   = lad;
    @(posedge LpcClock);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_oe"}, 16'(LAD_oe), 16'd0);
    chk({tag, "_stb"}, 16'({WrStrobe, RdStrobe}), 16'd0);
  endtask

  // Full LPC I/O cycle, ending after PTAR1 so the next call starts back-to-back.
  task automatic lpc_cycle(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                           input bit hit, input logic [7:0] exp_rd);
    logic [7:0] prev_addr;
    prev_addr = AddrReg;
    drive(1'b0, 4'h0);
    drive(1'b1, wr ? 4'h2 : 4'h0);
    drive(1'b1, a[15:12]);
    drive(1'b1, a[11:8]);
    drive(1'b1, a[7:4]);
    idle_chk("addr_nodrive");
    drive(1'b1, a[3:0]);
    if (!hit) begin
      chk("miss_addrreg", 16'(AddrReg), 16'(prev_addr));
      for (int i = 0; i < 7; i++) begin
        idle_chk("miss");
        drive(1'b1, 4'hF);
      end
      chk("miss_addrreg_end", 16'(AddrReg), 16'(prev_addr));
      return;
    end
    chk("addrreg", 16'(AddrReg), {11'd0, a[4:0]});
    if (wr) begin
      idle_chk("wdata0");
      drive(1'b1, wd[3:0]);
      drive(1'b1, wd[7:4]);
      chk("wrdata", 16'(WrData), 16'(wd));
    end
    chk("htar0_rdstb", 16'(RdStrobe), 16'(!wr));
    chk("htar0_oe", 16'(LAD_oe), 16'd0);
    drive(1'b1, 4'hF);
    idle_chk("htar1");
    drive(1'b1, 4'hF);
    for (int i = 0; i < WAITS; i++) begin
      chk("wait_lad", 16'({LAD_oe, LAD_out}), 16'h15);
      chk("wait_wrstb", 16'(WrStrobe), 16'd0);
      drive(1'b1, 4'hF);
    end
    chk("sync_lad", 16'({LAD_oe, LAD_out}), 16'h10);
    chk("sync_wrstb", 16'(WrStrobe), 16'(wr));
    chk("sync_rdstb", 16'(RdStrobe), 16'd0);
    if (wr) chk("sync_wr_ctx", {AddrReg, WrData}, {3'b000, a[4:0], wd});
    drive(1'b1, 4'hF);
    if (!wr) begin
      chk("rdata0", 16'({LAD_oe, LAD_out}), 16'({1'b1, exp_rd[3:0]}));
      drive(1'b1, 4'hF);
      chk("rdata1", 16'({LAD_oe, LAD_out}), 16'({1'b1, exp_rd[7:4]}));
      drive(1'b1, 4'hF);
    end
    chk("ptar0", 16'({LAD_oe, LAD_out}), 16'h1F);
    chk("ptar0_stb", 16'({WrStrobe, RdStrobe}), 16'd0);
    drive(1'b1, 4'hF);
    chk("ptar1", 16'({LAD_oe, LAD_out}), 16'h0F);
  endtask

  initial begin
    #5;
    chk("rst_lad", 16'({LAD_oe, LAD_out}), 16'h0F);
    chk("rst_regs", {AddrReg, WrData}, 16'h0000);
    chk("rst_stb", 16'({WrStrobe, RdStrobe}), 16'd0);
    @(posedge LpcClock); #1;
    PciReset = 1'b1;
    drive(1'b1, 4'hF);
    drive(1'b1, 4'hF);

    // Read 0x0701, then back-to-back write 0x070E = 0x3C
    lpc_cycle(1'b0, 16'h0701, 8'h00, 1'b1, 8'hA5);
    lpc_cycle(1'b1, 16'h070E, 8'h3C, 1'b1, 8'h00);

    // Out-of-window read
    lpc_cycle(1'b0, 16'h0800, 8'h00, 1'b0, 8'h00);

    // Abort with LAD=1111 during the 3rd address nibble
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h7);
    drive(1'b0, 4'hF);
    idle_chk("abort");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'hF);
      idle_chk("abort_idle");
    end
    chk("abort_addrreg", 16'(AddrReg), 16'h000E);
    lpc_cycle(1'b0, 16'h071F, 8'h00, 1'b1, 8'hBB);

    // Async reset in the middle of RDATA0
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h7);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h1);
    drive(1'b1, 4'hF);
    drive(1'b1, 4'hF);
    for (int i = 0; i < WAITS; i++) drive(1'b1, 4'hF);
    drive(1'b1, 4'hF);
    chk("pre_rst_rdata0", 16'({LAD_oe, LAD_out}), 16'h15);
    #5;
    PciReset = 1'b0;
    #2;
    chk("async_rst_lad", 16'({LAD_oe, LAD_out}), 16'h0F);
    chk("async_rst_regs", {AddrReg, WrData}, 16'h0000);
    chk("async_rst_stb", 16'({WrStrobe, RdStrobe}), 16'd0);
    @(posedge LpcClock); #1;
    PciReset = 1'b1;
    drive(1'b1, 4'hF);
    lpc_cycle(1'b0, 16'h0705, 8'h00, 1'b1, 8'hA1);

    // Write 0x0701 = 0x55 (wait SYNCs precede 0000 when enabled)
    lpc_cycle(1'b1, 16'h0701, 8'h55, 1'b1, 8'h00);
    drive(1'b1, 4'hF);
    idle_chk("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
